// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: result-select
// encodings, the access state machine states and the MEM/WB register bundle.
package mem_access_stage_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_IO  = 2'b10;

  localparam int WDOG_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [31:0] result;
    logic [3:0]  rd;
  } mw_bundle_t;

  // IO-flagged MEM selects are IO-space reads and never touch data memory.
  function automatic logic is_dmem_op(input logic mem_write, input logic [1:0] mem_to_reg,
                                      input logic io_flag);
    return mem_write | ((mem_to_reg == MTR_MEM) & ~io_flag);
  endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register; a stall loads an all-zero bubble instead of the
// incoming bundle.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        m_reg_write,
  input  logic [1:0]  m_mem_to_reg,
  input  logic [31:0] m_result,
  input  logic [3:0]  m_rd,
  output logic        w_reg_write,
  output logic [1:0]  w_mem_to_reg,
  output logic [31:0] w_result,
  output logic [3:0]  w_rd
);

  mw_bundle_t bundle_reg;
  mw_bundle_t bundle_next;

  always_comb begin
    bundle_next = '0;
    if (!stall) begin
      bundle_next.reg_write  = m_reg_write;
      bundle_next.mem_to_reg = m_mem_to_reg;
      bundle_next.result     = m_result;
      bundle_next.rd         = m_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_reg <= '0;
    end else begin
      bundle_reg <= bundle_next;
    end
  end

  assign w_reg_write  = bundle_reg.reg_write;
  assign w_mem_to_reg = bundle_reg.mem_to_reg;
  assign w_result     = bundle_reg.result;
  assign w_rd         = bundle_reg.rd;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: data-memory req/ack accesses with a watchdog,
// single-cycle pixel writes, IO read sampling and the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemPWriteM,
  input  logic        IOFlagM,
  input  logic [1:0]  MemToRegM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  RdM,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        pmem_we,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] io_rdata,
  output logic        RegWriteW,
  output logic [1:0]  MemToRegW,
  output logic [31:0] ResultW,
  output logic [3:0]  RdW,
  output logic        mem_err
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;

  mem_state_t        state_reg, state_next;
  logic [WDOG_W-1:0] wdog_reg, wdog_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic              err_reg, err_next;

  logic              dmem_op;
  logic              in_idle;
  logic              in_wait;
  logic              timeout;
  logic              complete;
  logic [31:0]       m_result;

  assign dmem_op  = is_dmem_op(MemWriteM, MemToRegM, IOFlagM);
  assign in_idle  = (state_reg == IDLE);
  assign in_wait  = (state_reg == WAIT);
  // An ack in the final watchdog cycle takes priority over the timeout.
  assign timeout  = in_wait & ~dmem_ack & (wdog_reg == WDOG_LIMIT);
  assign complete = in_wait & (dmem_ack | timeout);

  always_comb begin
    state_next = state_reg;
    wdog_next  = wdog_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = we_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (dmem_op) begin
          state_next = WAIT;
          addr_next  = ALUResultM;
          wdata_next = WriteDataM;
          we_next    = MemWriteM;
          wdog_next  = '0;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_next = IDLE;
        end else if (timeout) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (wdog_reg != WDOG_MAX) begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      wdog_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wdog_reg  <= wdog_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      err_reg   <= err_next;
    end
  end

  assign StallM = ~rst & ((in_idle & dmem_op) | (in_wait & ~dmem_ack & ~timeout));

  assign dmem_req   = in_wait;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign mem_err    = err_reg;

  assign pmem_we    = ~rst & MemPWriteM & in_idle & ~dmem_op;
  assign pmem_addr  = ALUResultM;
  assign pmem_wdata = WriteDataM;

  // A timed-out access completes with zero read data.
  always_comb begin
    m_result = ALUResultM;
    if (complete) begin
      m_result = dmem_ack ? dmem_rdata : 32'h0;
    end else if (IOFlagM && (MemToRegM == MTR_IO)) begin
      m_result = io_rdata;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (StallM),
    .m_reg_write  (RegWriteM),
    .m_mem_to_reg (MemToRegM),
    .m_result     (m_result),
    .m_rd         (RdM),
    .w_reg_write  (RegWriteW),
    .w_mem_to_reg (MemToRegW),
    .w_result     (ResultW),
    .w_rd         (RdW)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// instructions checked against a transaction-level model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, MemPWriteM, IOFlagM;
  logic [1:0]  MemToRegM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  RdM;
  logic        StallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        pmem_we;
  logic [31:0] pmem_addr, pmem_wdata, io_rdata;
  logic        RegWriteW;
  logic [1:0]  MemToRegW;
  logic [31:0] ResultW;
  logic [3:0]  RdW;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemPWriteM(MemPWriteM), .IOFlagM(IOFlagM),
    .MemToRegM(MemToRegM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pmem_we(pmem_we), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .io_rdata(io_rdata),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ResultW(ResultW), .RdW(RdW),
    .mem_err(mem_err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic err_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    RegWriteM = 0; MemWriteM = 0; MemPWriteM = 0; IOFlagM = 0; MemToRegM = 2'b00;
    ALUResultM = 0; WriteDataM = 0; RdM = 0; dmem_rdata = 0; dmem_ack = 0; io_rdata = 0;
  endtask

  // One instruction presented just after a rising edge and held while stalled.
  // ack_at = index of the req cycle carrying the ack (0 = first), negative = never.
  task automatic run_instr(input logic rw, input logic mw, input logic pw, input logic iof,
                           input logic [1:0] mtr, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [3:0] rd, input logic [31:0] rdata, input logic [31:0] io,
                           input int ack_at, input logic stray_ack);
    bit          op, timed_out, done;
    int          exp_stall, stalls, pulses;
    logic [31:0] exp_res;
    RegWriteM = rw; MemWriteM = mw; MemPWriteM = pw; IOFlagM = iof; MemToRegM = mtr;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; dmem_rdata = rdata; io_rdata = io;

    op        = mw || (mtr == 2'b01 && !iof);
    timed_out = op && (ack_at < 0 || ack_at > TO - 1);
    exp_stall = !op ? 0 : (timed_out ? TO : ack_at + 1);
    if (op)                        exp_res = timed_out ? 32'h0 : rdata;
    else if (iof && mtr == 2'b10)  exp_res = io;
    else                           exp_res = alu;

    stalls = 0; pulses = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      dmem_ack = op ? (c - 1 == ack_at) : stray_ack;
      @(negedge clk);
      check("dmem_req", 32'(dmem_req), 32'(op && c >= 1));
      if (op && c >= 1) begin
        check("dmem_addr", dmem_addr, alu);
        check("dmem_wdata", dmem_wdata, wd);
        check("dmem_we", 32'(dmem_we), 32'(mw));
      end
      if (c >= 1) begin
        check("bubble_regwrite", 32'(RegWriteW), 32'd0);
        check("bubble_result", ResultW, 32'd0);
        check("bubble_rd", 32'(RdW), 32'd0);
      end
      if (pmem_we) begin
        pulses++;
        check("pmem_addr", pmem_addr, alu);
        check("pmem_wdata", pmem_wdata, wd);
      end
      if (StallM) stalls++;
      else        done = 1;
      @(posedge clk); #1;
    end
    dmem_ack = 0;
    check("completed", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("pmem_pulses", 32'(pulses), 32'(pw && !op));
    err_model = err_model | timed_out;
    check("RegWriteW", 32'(RegWriteW), 32'(rw));
    check("MemToRegW", 32'(MemToRegW), 32'(mtr));
    check("ResultW", ResultW, exp_res);
    check("RdW", 32'(RdW), 32'(rd));
    check("mem_err", 32'(mem_err), 32'(err_model));
    $display("instr rw=%0d mw=%0d pw=%0d io=%0d mtr=%0d alu=%h ack_at=%0d stalls=%0d result=%h err=%0d",
             rw, mw, pw, iof, mtr, alu, ack_at, stalls, ResultW, mem_err);
  endtask

  initial begin
    int          kind, ack_at;
    logic [1:0]  mtr;
    logic        iof, mw, pw;

    zero_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_pmem_we", 32'(pmem_we), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_regwrite", 32'(RegWriteW), 32'd0);
    check("rst_result", ResultW, 32'd0);
    check("rst_rd", 32'(RdW), 32'd0);
    check("rst_mtr", 32'(MemToRegW), 32'd0);
    $display("reset checked");
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU pass-through with a stray ack that must be ignored
    run_instr(1, 0, 0, 0, 2'b00, 32'h15, 32'h0, 4'hA, 32'h0, 32'h0, -1, 1'b1);
    // Load acked three cycles after req rises
    run_instr(1, 0, 0, 0, 2'b01, 32'h100, 32'h0, 4'h3, 32'hDEADBEEF, 32'h0, 3, 1'b0);
    // Zero-wait store
    run_instr(0, 1, 0, 0, 2'b00, 32'h40, 32'hB, 4'h0, 32'h12345678, 32'h0, 0, 1'b0);
    // Pixel write then IO read back-to-back
    run_instr(0, 0, 1, 0, 2'b00, 32'h200, 32'h77, 4'h0, 32'h0, 32'h0, -1, 1'b0);
    run_instr(1, 0, 0, 1, 2'b10, 32'h300, 32'h0, 4'h5, 32'h0, 32'h55, -1, 1'b0);
    // Ack in the last watchdog cycle beats the timeout
    run_instr(1, 0, 0, 0, 2'b01, 32'h104, 32'h0, 4'h6, 32'hCAFEF00D, 32'h0, TO - 1, 1'b0);
    // Timeout with no ack
    run_instr(1, 0, 0, 0, 2'b01, 32'h108, 32'h0, 4'h7, 32'hFFFFFFFF, 32'h0, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind   = int'($urandom_range(0, 5));
      ack_at = int'($urandom_range(0, 6)) - 1;
      mw = 0; pw = 0; iof = $urandom_range(0, 1) == 1;
      case (kind)
        0:       mtr = 2'b00;
        1:       begin mtr = 2'b01; iof = ($urandom_range(0, 3) == 0); end
        2:       begin mtr = 2'b00; mw = 1; end
        3:       begin mtr = 2'b00; pw = 1; end
        4:       begin mtr = 2'b10; iof = 1; end
        default: mtr = 2'b11;
      endcase
      run_instr($urandom_range(0, 1) == 1, mw, pw, iof, mtr, $urandom, $urandom,
                4'($urandom), $urandom, $urandom, ack_at, $urandom_range(0, 1) == 1);
    end

    // Reset while waiting for an ack, then a late ack in IDLE
    RegWriteM = 1; MemWriteM = 0; MemPWriteM = 0; IOFlagM = 0; MemToRegM = 2'b01;
    ALUResultM = 32'h500; WriteDataM = 0; RdM = 4'h9; dmem_ack = 0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("wait_req_before_rst", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    zero_inputs();
    dmem_ack = 1'b1;
    err_model = 1'b0;
    @(negedge clk);
    check("rst_wait_req", 32'(dmem_req), 32'd0);
    check("rst_wait_err", 32'(mem_err), 32'd0);
    check("rst_wait_regwrite", 32'(RegWriteW), 32'd0);
    check("rst_wait_result", ResultW, 32'd0);
    check("rst_wait_rd", 32'(RdW), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_stall", 32'(StallM), 32'd0);
    $display("reset in WAIT checked");
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    run_instr(1, 0, 0, 0, 2'b01, 32'h600, 32'h0, 4'hC, 32'h0BADC0DE, 32'h0, 1, 1'b0);
    run_instr(1, 0, 0, 0, 2'b00, 32'h21, 32'h0, 4'h1, 32'h0, 32'h0, -1, 1'b0);
    zero_inputs();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage of the hybrid ARM/MIPS core: the consumer of the execute stage's output bundle. It performs data-memory loads and stores over a req/ack handshake, issues single-cycle pixel-memory writes, samples the IO read port, and registers the result into the MEM/WB pipeline register. Multi-cycle memory accesses back-pressure the upstream pipeline through `StallM`. A watchdog flags and terminates accesses that never complete.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum number of cycles to wait for `dmem_ack` (range 1..255; the counter is 8 bits).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `RegWriteM`, `MemWriteM`, `MemPWriteM`, `IOFlagM` in 1 each: control bits from execute.
- `MemToRegM` in 2: result select. 00 = ALU, 01 = data memory, 10 = IO, 11 = treated as ALU.
- `ALUResultM` in 32: address or ALU result.
- `WriteDataM` in 32: store data.
- `RdM` in 4: destination register.
- `StallM` out 1: hold execute/MEM inputs stable and freeze upstream.
- `dmem_req` out 1; `dmem_we` out 1; `dmem_addr` out 32; `dmem_wdata` out 32: data-memory request side.
- `dmem_rdata` in 32; `dmem_ack` in 1: data-memory response side.
- `pmem_we` out 1; `pmem_addr` out 32; `pmem_wdata` out 32: pixel-memory write port.
- `io_rdata` in 32: combinational IO read data.
- `RegWriteW` out 1; `MemToRegW` out 2; `ResultW` out 32; `RdW` out 4: outputs to writeback.
- `mem_err` out 1: sticky timeout flag.

## Operation
- `dmem_op` = `MemWriteM` | (`MemToRegM` == 01 & !`IOFlagM`).
- State machine, states IDLE and WAIT:
  - IDLE with `dmem_op`: latch `dmem_addr` = `ALUResultM`, `dmem_wdata` = `WriteDataM`, `dmem_we` = `MemWriteM`; clear the watchdog; go to WAIT.
  - WAIT: `dmem_req` = 1.
  - WAIT with `dmem_ack`: return to IDLE.
  - WAIT with watchdog == `TIMEOUT` - 1 and no ack: set `mem_err`, return to IDLE, and complete the access with read data 0.
- `StallM` = (IDLE & `dmem_op`) | (WAIT & !`dmem_ack` & !timeout).
- Pixel writes:
  - `pmem_we` = `MemPWriteM` & IDLE & !`dmem_op`.
  - `pmem_addr` = `ALUResultM`; `pmem_wdata` = `WriteDataM`.
  - Exactly one pulse per instruction.
- `ResultW` select:
  - `dmem_rdata` on the completing ack.
  - `io_rdata` when `IOFlagM` & `MemToRegM` == 10.
  - `ALUResultM` otherwise.
- W register behaviour:
  - Loads on every non-stalled cycle.
  - While `StallM` = 1 it loads a bubble: `RegWriteW` = 0, `RdW` = 0, `MemToRegW` = 00, `ResultW` = 0.
- Stores write no register; `RegWriteW` follows `RegWriteM` unchanged.
- `mem_err` is cleared only by reset.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req`, `dmem_we`, `pmem_we`, `StallM` = 0; `mem_err` = 0.
  - `dmem_addr`, `dmem_wdata` = 0; watchdog = 0.
  - All W outputs = 0.
- Reset in WAIT: `dmem_req` drops on the next edge, and a late ack is ignored.
- Non-memory instruction: 1-cycle latency to the W outputs, no stall.
- Memory instruction with ack N cycles after `dmem_req` rises (N ≥ 0):
  - `StallM` high for N + 1 cycles.
  - W is updated at the edge ending the ack cycle.
- `dmem_req` stays high until the ack cycle or timeout, and is never asserted in IDLE.
- `dmem_ack` seen in IDLE is ignored.
- Ack arriving in the same cycle as timeout: the ack wins and `mem_err` is not set.
- The watchdog saturates and never wraps.

## Structure
- Shared pipeline package holds:
  - the `MemToReg` encoding constants (`MTR_ALU`, `MTR_MEM`, `MTR_IO`);
  - a `mem_state_t` enum (IDLE, WAIT);
  - a packed `mw_bundle_t` struct for the W register.
- One sub-module, `mem_wb_reg`: the bubble-capable MEM/WB pipeline register, with `stall` inserting a bubble.

## Test plan
- ALU pass-through: `RegWriteM` = 1, `MemToRegM` = 00, `ALUResultM` = 0x15, `RdM` = 0xA -> next cycle `RegWriteW` = 1, `ResultW` = 0x15, `RdW` = 0xA; `StallM` never high.
- Load with ack after 3 cycles: `MemToRegM` = 01, `ALUResultM` = 0x100, `dmem_rdata` = 0xDEADBEEF -> `dmem_req` high with `dmem_addr` = 0x100; `StallM` high for 4 cycles; then `ResultW` = 0xDEADBEEF.
- Store with zero-wait ack: `MemWriteM` = 1, `WriteDataM` = 0xB, ack in the first req cycle -> `dmem_we` = 1, `dmem_wdata` = 0xB, one stall cycle, `RegWriteW` = 0.
- Pixel write plus IO read back-to-back -> `pmem_we` pulses exactly once with `ALUResultM`/`WriteDataM`; then `ResultW` = `io_rdata` = 0x55.
- Timeout with `TIMEOUT` = 4 and no ack -> `StallM` high for 4 cycles, then `mem_err` = 1 and `ResultW` = 0.
- Reset in WAIT -> `dmem_req` = 0, `mem_err` = 0, and W outputs zero on the next cycle.
